// File: rtl/serial_frame_rx_if.sv
// Serial receiver bundle: line in, parallel word and status out.
// master drives the line; slave is the receiver side.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             si;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;

    modport master (
        output si,
        input  dout,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  si,
        output dout,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even
// parity, low stop bit; good words land on dout with a valid pulse.
module serial_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input logic         clk,
    input logic         rst,
    serial_frame_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] dout;
    logic             pbit;
    logic             valid;
    logic             frame_err;
    logic             parity_err;
    logic             valid_nx;
    logic             ferr_nx;
    logic             perr_nx;
    logic             last_bit;
    logic             par_bad;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Even parity: data bits plus parity bit must XOR to zero
    assign par_bad  = PARITY_EN && ((^sr) ^ pbit);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (bus.si) state_nx = DATA;
            DATA:   if (last_bit)
                        state_nx = PARITY_EN ? PARITY : STOP;
            PARITY: state_nx = STOP;
            STOP:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        valid_nx = 1'b0;
        ferr_nx  = 1'b0;
        perr_nx  = 1'b0;
        if (state == STOP) begin
            ferr_nx  = bus.si;
            perr_nx  = par_bad;
            valid_nx = !bus.si && !par_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sr         <= '0;
            pbit       <= 1'b0;
            dout       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= valid_nx;
            frame_err  <= ferr_nx;
            parity_err <= perr_nx;
            unique case (state)
                IDLE:   if (bus.si) cnt <= '0;
                DATA: begin
                    sr  <= {bus.si, sr[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                PARITY: pbit <= bus.si;
                STOP:   if (valid_nx) dout <= sr;
            endcase
        end
    end

    assign bus.dout       = dout;
    assign bus.valid      = valid;
    assign bus.frame_err  = frame_err;
    assign bus.parity_err = parity_err;
    assign bus.busy       = (state != IDLE);
endmodule
